// File: rtl/mux1hot_pkg.sv
// mux1hot_pkg: shared occupancy encoding and select helpers for mux1hot_pipe
//   MAX_N      : widest select vector the helper functions accept
//   ST_*       : skid occupancy; bit0 = main entry valid, bit1 = skid entry valid
//   is_onehot  : exactly one bit set
//   lowest_set : isolates the lowest set bit (zero stays zero)
package mux1hot_pkg;
   localparam int MAX_N = 64;
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;
   function automatic logic is_onehot(input logic [MAX_N-1:0] v);
      return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
   endfunction
   function automatic logic [MAX_N-1:0] lowest_set(input logic [MAX_N-1:0] v);
      return v & (~v + MAX_N'(1));
   endfunction
endpackage

// File: rtl/mux1hot_skid.sv
// mux1hot_skid: two-entry skid buffer, full throughput with a registered in_ready
//   clk, rst (async, active-high)
//   in_data/in_valid/in_ready    : upstream beat; in_ready is the inverted skid-valid flop
//   out_data/out_valid/out_ready : downstream beat, driven straight from the main entry
module mux1hot_skid
   import mux1hot_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             w_acc;
   logic             w_xfer;
   logic [1:0]       w_next;
   assign in_ready  = ~r_state[1];
   assign out_valid = r_state[0];
   assign out_data  = r_main;
   assign w_acc     = in_valid & in_ready;
   assign w_xfer    = out_valid & out_ready;
   always_comb begin
      w_next = (r_state == ST_EMPTY) ? (w_acc ? ST_ONE : ST_EMPTY) :
               (r_state == ST_ONE)   ? ((w_acc && !w_xfer) ? ST_FULL :
                                        (!w_acc && w_xfer) ? ST_EMPTY : ST_ONE) :
                                       (w_xfer ? ST_ONE : ST_FULL);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_next;
         // skid refills main on a transfer; otherwise a new beat lands in main when it frees up
         if (w_xfer && r_state[1])
            r_main <= r_skid;
         else if (w_acc && (!r_state[0] || w_xfer))
            r_main <= in_data;
         if (w_acc && r_state[0] && !w_xfer)
            r_skid <= in_data;
      end
   end
endmodule

// File: rtl/mux1hot_pipe.sv
// mux1hot_pipe: pipelined one-hot N:1 mux behind a valid/ready skid buffer
//   clk, rst (async, active-high)
//   in_data[N*WIDTH], in_sel[N], in_valid, in_ready : upstream beat and select
//   out_data[WIDTH], out_valid, out_ready          : registered selected data
//   err, err_cnt[CNT_W]                            : dropped illegal-select pulse / saturating count
//   MUX1HOT_SEL_CHECK_EN: when defined, illegal selects are dropped and counted;
//   otherwise the lowest set select bit wins and err/err_cnt are tied to 0
module mux1hot_pipe
   import mux1hot_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               err,
   output logic [CNT_W-1:0]   err_cnt
);
   logic [N-1:0]     w_sel;
   logic [WIDTH-1:0] w_mux;
   logic             w_skid_valid;
   // masking to the lowest bit keeps the AND-OR tree a true mux even for multi-hot selects
   assign w_sel = N'(lowest_set(MAX_N'(in_sel)));
   always_comb begin
      w_mux = '0;
      for (int i = 0; i < N; i++)
         w_mux = w_mux | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_sel[i]}});
   end
`ifdef MUX1HOT_SEL_CHECK_EN
   logic             w_legal;
   logic             w_drop;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   assign w_legal      = is_onehot(MAX_N'(in_sel));
   // an illegal beat is still accepted upstream but never enters the buffer
   assign w_skid_valid = in_valid & w_legal;
   assign w_drop       = in_valid & in_ready & ~w_legal;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_err <= w_drop;
         if (w_drop && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end
   assign err     = r_err;
   assign err_cnt = r_cnt;
`else
   assign w_skid_valid = in_valid;
   assign err          = 1'b0;
   assign err_cnt      = '0;
`endif
   mux1hot_skid #(.WIDTH(WIDTH)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_data  (w_mux),
      .in_valid (w_skid_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );
endmodule

// File: tb/tb_mux1hot_pipe.sv
// tb_mux1hot_pipe: scoreboard bench for mux1hot_pipe (N=4, WIDTH=8; second instance with CNT_W=2)
module tb_mux1hot_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic [3:0]  in_sel = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, err;
   logic [7:0]  out_data, err_cnt;
   logic        in_ready2, out_valid2, err2;
   logic [7:0]  out_data2;
   logic [1:0]  err_cnt2;
`ifdef MUX1HOT_SEL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   always #5 clk = ~clk;
   mux1hot_pipe #(.WIDTH(8), .N(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .err(err), .err_cnt(err_cnt));
   mux1hot_pipe #(.WIDTH(8), .N(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
      .err(err2), .err_cnt(err_cnt2));
   int         n_vec = 0;
   int         n_bad = 0;
   int         n_drop = 0;
   bit         exp_err = 1'b0;
   logic [7:0] q[$];
   logic [7:0] mv;
   bit         keep;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // reference: a beat is forwarded unless checking is on and the select is not exactly one-hot
   function automatic bit model(input logic [31:0] d, input logic [3:0] s, output logic [7:0] v);
      v = 8'h00;
      if (CHK && $countones(s) != 1) return 1'b0;
      for (int i = 3; i >= 0; i--)
         if (s[i]) v = d[i*8 +: 8];
      return 1'b1;
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         exp_err = 1'b0;
         n_drop  = 0;
      end else begin
         exp_err = 1'b0;
         if (in_valid && in_ready) begin
            keep = model(in_data, in_sel, mv);
            if (keep) q.push_back(mv);
            else begin
               exp_err = 1'b1;
               n_drop++;
            end
         end
      end
   end
   always @(negedge clk) begin
      if (rst) begin
         check("rst out_valid", out_valid, 0);
         check("rst out_data", out_data, 0);
         check("rst in_ready", in_ready, 1);
         check("rst err", err, 0);
         check("rst err_cnt", err_cnt, 0);
         check("rst err_cnt2", err_cnt2, 0);
      end else begin
         check("out_valid", out_valid, q.size() > 0);
         check("in_ready", in_ready, q.size() < 2);
         check("err", err, exp_err);
         check("err_cnt", err_cnt, CHK ? ((n_drop > 255) ? 255 : n_drop) : 0);
         check("err_cnt2", err_cnt2, CHK ? ((n_drop > 3) ? 3 : n_drop) : 0);
         if (out_valid && out_ready && q.size() > 0)
            check("out_data", out_data, q.pop_front());
      end
   end
   task automatic beat(input bit v, input logic [3:0] s, input logic [31:0] d, input bit rdy);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = rdy;
   endtask
   task automatic pulse_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async out_valid", out_valid, 0);
      check("async in_ready", in_ready, 1);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask
   function automatic logic [3:0] legal_sel();
      return 4'b0001 << $urandom_range(3, 0);
   endfunction
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      beat(1, 4'b0100, {8'h11, 8'hA5, 8'h22, 8'h33}, 1);
      beat(0, 4'b0000, 32'h0, 1);
      beat(1, 4'b0110, {8'h44, 8'h55, 8'h66, 8'h77}, 1);
      beat(1, 4'b0000, {8'h88, 8'h99, 8'hAA, 8'hBB}, 1);
      beat(1, 4'b0001, {8'hCC, 8'hDD, 8'hEE, 8'h5A}, 1);
      repeat (2) beat(0, 4'b0000, 32'h0, 1);
      pulse_reset();
      for (int i = 0; i < 5; i++) beat(1, (i % 2) ? 4'b0000 : 4'b1010, $urandom, 1);
      repeat (2) beat(0, 4'b0000, 32'h0, 1);
      for (int i = 0; i < 16; i++) beat(1, legal_sel(), $urandom, 1);
      for (int i = 0; i < 12; i++) beat(1, legal_sel(), $urandom, !(i >= 3 && i < 6));
      for (int i = 0; i < 400; i++)
         beat(($urandom % 4) != 0, 4'($urandom_range(15, 0)), $urandom, ($urandom % 3) != 0);
      for (int i = 0; i < 3; i++) beat(1, legal_sel(), $urandom, 0);
      pulse_reset();
      repeat (5) beat(0, 4'b0000, 32'h0, 1);
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      check("drain", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
